// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control width, register zero and the
// operand forward-select encoding used by the ID/EX operand stage.
package pipe_pkg;

    localparam int CTRL_W = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_EX   = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_e;

    // Picks the operand source in priority order: $0, EX writer, MEM writer, register file.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] idx,
        input logic       ex_fwd_en,
        input logic [4:0] ex_rd,
        input logic       mem_w_en,
        input logic [4:0] mem_rd
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (idx == REG_ZERO) begin
            sel = FWD_ZERO;
        end else if (ex_fwd_en && (ex_rd == idx)) begin
            sel = FWD_EX;
        end else if (mem_w_en && (mem_rd == idx) && (mem_rd != REG_ZERO)) begin
            sel = FWD_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// One operand's forwarding mux: chooses between zero, the EX result,
// the MEM result and the register file read data.
module operand_fwd_mux
    import pipe_pkg::*;
(
    input  logic [4:0]  idx_i,
    input  logic        ex_fwd_en_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        mem_w_en_i,
    input  logic [4:0]  mem_rd_i,
    input  logic [31:0] rf_data_i,
    input  logic [31:0] ex_data_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] operand_o
);

    fwd_sel_e sel;

    // Resolve the source for this operand and steer the matching data through.
    always_comb begin
        sel = fwd_select(idx_i, ex_fwd_en_i, ex_rd_i, mem_w_en_i, mem_rd_i);
        operand_o = rf_data_i;
        case (sel)
            FWD_ZERO: operand_o = 32'd0;
            FWD_EX:   operand_o = ex_data_i;
            FWD_MEM:  operand_o = mem_data_i;
            default:  operand_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with operand forwarding, load-use stall and
// bubble insertion, global enable, flush, and a saturating bubble counter.
module id_ex_operand_stage #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_w_en,
    input  logic              id_mem_read,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       rf_data_a,
    input  logic [31:0]       rf_data_b,
    input  logic [31:0]       ex_alu_result,
    input  logic              mem_w_en,
    input  logic [4:0]        mem_rd,
    input  logic [31:0]       mem_data,
    output logic              stall_id,
    output logic              ex_valid,
    output logic              ex_w_en,
    output logic              ex_mem_read,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_op_a,
    output logic [31:0]       ex_op_b,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import pipe_pkg::*;

    logic              valid_q, valid_d;
    logic              w_en_q, w_en_d;
    logic              mem_read_q, mem_read_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic        held_writer;
    logic        ex_fwd_en;
    logic        hazard;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    // A held load cannot forward yet; a held ALU writer can.
    assign held_writer = valid_q & w_en_q & (rd_q != REG_ZERO);
    assign ex_fwd_en   = held_writer & ~mem_read_q;
    assign hazard      = id_valid & held_writer & mem_read_q &
                         ((id_rs == rd_q) | (id_rt == rd_q));
    assign stall_id    = hazard & ~flush & en;

    operand_fwd_mux u_fwd_rs (
        .idx_i       (id_rs),
        .ex_fwd_en_i (ex_fwd_en),
        .ex_rd_i     (rd_q),
        .mem_w_en_i  (mem_w_en),
        .mem_rd_i    (mem_rd),
        .rf_data_i   (rf_data_a),
        .ex_data_i   (ex_alu_result),
        .mem_data_i  (mem_data),
        .operand_o   (fwd_a)
    );

    operand_fwd_mux u_fwd_rt (
        .idx_i       (id_rt),
        .ex_fwd_en_i (ex_fwd_en),
        .ex_rd_i     (rd_q),
        .mem_w_en_i  (mem_w_en),
        .mem_rd_i    (mem_rd),
        .rf_data_i   (rf_data_b),
        .ex_data_i   (ex_alu_result),
        .mem_data_i  (mem_data),
        .operand_o   (fwd_b)
    );

    // Next state: hold when disabled, else flush bubble, hazard bubble (counted), or load ID.
    always_comb begin
        valid_d    = valid_q;
        w_en_d     = w_en_q;
        mem_read_d = mem_read_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        cnt_d      = cnt_q;
        if (en) begin
            if (flush || hazard) begin
                valid_d    = 1'b0;
                w_en_d     = 1'b0;
                mem_read_d = 1'b0;
                rd_d       = REG_ZERO;
                ctrl_d     = '0;
                op_a_d     = 32'd0;
                op_b_d     = 32'd0;
                if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                valid_d    = id_valid;
                w_en_d     = id_w_en;
                mem_read_d = id_mem_read;
                rd_d       = id_rd;
                ctrl_d     = id_ctrl;
                op_a_d     = fwd_a;
                op_b_d     = fwd_b;
            end
        end
    end

    // Stage registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            w_en_q     <= 1'b0;
            mem_read_q <= 1'b0;
            rd_q       <= REG_ZERO;
            ctrl_q     <= '0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            w_en_q     <= w_en_d;
            mem_read_q <= mem_read_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_w_en     = w_en_q;
    assign ex_mem_read = mem_read_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_op_a     = op_a_q;
    assign ex_op_b     = op_b_q;
    assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a reference model pushes the
// expected stage contents on every clock and the popped entry is compared
// against the registered outputs just after the edge.
module tb_id_ex_operand_stage;

    localparam int CW = 16;
    localparam int NW = 4;

    typedef struct packed {
        logic          v;
        logic          w;
        logic          mr;
        logic [4:0]    rd;
        logic [CW-1:0] ctrl;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [NW-1:0] cnt;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, flush, id_valid, id_w_en, id_mem_read, mem_w_en;
    logic [4:0]    id_rs, id_rt, id_rd, mem_rd;
    logic [CW-1:0] id_ctrl;
    logic [31:0]   rf_data_a, rf_data_b, ex_alu_result, mem_data;
    logic          stall_id, ex_valid, ex_w_en, ex_mem_read;
    logic [4:0]    ex_rd;
    logic [CW-1:0] ex_ctrl;
    logic [31:0]   ex_op_a, ex_op_b;
    logic [NW-1:0] bubble_cnt;

    out_t mdl;
    out_t sbq[$];
    int   checkCount = 0;
    int   errorCount = 0;

    id_ex_operand_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_w_en(id_w_en), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .ex_alu_result(ex_alu_result),
        .mem_w_en(mem_w_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_w_en(ex_w_en),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t o;
        o.v = ex_valid; o.w = ex_w_en; o.mr = ex_mem_read; o.rd = ex_rd;
        o.ctrl = ex_ctrl; o.a = ex_op_a; o.b = ex_op_b; o.cnt = bubble_cnt;
        return o;
    endfunction

    // Reference model of the stage, written from the operation description.
    function automatic logic m_writer();
        return mdl.v && mdl.w && (mdl.rd != 5'd0);
    endfunction

    function automatic logic m_hazard();
        return id_valid && m_writer() && mdl.mr && (id_rs == mdl.rd || id_rt == mdl.rd);
    endfunction

    function automatic logic m_stall();
        return m_hazard() && !flush && en;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
        if (m_writer() && !mdl.mr && mdl.rd == idx) return ex_alu_result;
        if (mem_w_en && mem_rd == idx) return mem_data;
        return rf;
    endfunction

    function automatic out_t m_next();
        out_t nx;
        nx = mdl;
        if (en) begin
            if (flush) begin
                nx = '0;
                nx.cnt = mdl.cnt;
            end else if (m_hazard()) begin
                nx = '0;
                nx.cnt = (mdl.cnt == {NW{1'b1}}) ? mdl.cnt : mdl.cnt + 1'b1;
            end else begin
                nx.v = id_valid; nx.w = id_w_en; nx.mr = id_mem_read; nx.rd = id_rd;
                nx.ctrl = id_ctrl;
                nx.a = m_fwd(id_rs, rf_data_a);
                nx.b = m_fwd(id_rt, rf_data_b);
            end
        end
        return nx;
    endfunction

    // Push the model's prediction, then let the DUT take the edge.
    task automatic step();
        out_t nx;
        nx = m_next();
        sbq.push_back(nx);
        mdl = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic w, input logic mr,
                          input logic [31:0] ra, input logic [31:0] rb);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_w_en = w;
        id_mem_read = mr; rf_data_a = ra; rf_data_b = rb;
        id_ctrl = CW'($urandom);
    endtask

    task automatic idle_inputs();
        en = 1'b1; flush = 1'b0; mem_w_en = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        ex_alu_result = 32'd0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        out_t got, exp;
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        mdl = '0;
        exp = '0;
        got = dut_out();
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL reset_outputs got=%h exp=%h", got, exp);
        end
        checkCount++;
        if (stall_id !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_stall got=%b exp=0", stall_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ex_forward();
        out_t got, exp;
        @(negedge clk);
        idle_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 32'hA, 32'hB);
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL load_add got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        ex_alu_result = 32'h1234;
        set_id(1'b1, 5'd8, 5'd3, 5'd4, 1'b1, 1'b0, 32'hDEAD, 32'h7);
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL ex_fwd_stage got=%h exp=%h", got, exp);
        end
        checkCount++;
        if (ex_op_a !== 32'h1234) begin
            errorCount++;
            $display("[TB] FAIL ex_fwd_op_a got=%h exp=00001234", ex_op_a);
        end
    endtask

    task automatic test_fwd_priority();
        out_t got, exp;
        @(negedge clk);
        idle_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 32'h1, 32'h2);
        step();
        void'(sbq.pop_front());
        @(negedge clk);
        ex_alu_result = 32'h11; mem_w_en = 1'b1; mem_rd = 5'd9; mem_data = 32'h22;
        set_id(1'b1, 5'd1, 5'd9, 5'd5, 1'b1, 1'b0, 32'h3, 32'h33);
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp || ex_op_b !== 32'h11) begin
            errorCount++;
            $display("[TB] FAIL ex_over_mem got=%h exp=%h op_b=%h", got, exp, ex_op_b);
        end
        @(negedge clk);
        ex_alu_result = 32'h77; mem_w_en = 1'b1; mem_rd = 5'd0; mem_data = 32'h5;
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 32'h99, 32'h98);
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp || ex_op_a !== 32'd0 || ex_op_b !== 32'd0) begin
            errorCount++;
            $display("[TB] FAIL reg_zero got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        ex_alu_result = 32'h0; mem_w_en = 1'b1; mem_rd = 5'd13; mem_data = 32'h5A5A;
        set_id(1'b1, 5'd13, 5'd14, 5'd7, 1'b0, 1'b0, 32'h1, 32'h2);
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp || ex_op_a !== 32'h5A5A) begin
            errorCount++;
            $display("[TB] FAIL mem_fwd got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_load_use();
        out_t got, exp;
        @(negedge clk);
        idle_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        void'(sbq.pop_front());
        @(negedge clk);
        ex_alu_result = 32'hCAFE;
        set_id(1'b1, 5'd10, 5'd3, 5'd11, 1'b1, 1'b0, 32'hBAD, 32'h3);
        #1;
        checkCount++;
        if (stall_id !== 1'b1 || m_stall() !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL lu_stall got=%b exp=1", stall_id);
        end
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp || ex_valid !== 1'b0 || bubble_cnt !== 4'd1) begin
            errorCount++;
            $display("[TB] FAIL lu_bubble got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        mem_w_en = 1'b1; mem_rd = 5'd10; mem_data = 32'h400;
        #1;
        checkCount++;
        if (stall_id !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL lu_stall_drop got=%b exp=0", stall_id);
        end
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp || ex_op_a !== 32'h400) begin
            errorCount++;
            $display("[TB] FAIL lu_mem_fwd got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_flush_hazard();
        out_t got, exp;
        @(negedge clk);
        idle_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        void'(sbq.pop_front());
        @(negedge clk);
        flush = 1'b1;
        set_id(1'b1, 5'd4, 5'd10, 5'd11, 1'b1, 1'b0, 32'h1, 32'h2);
        #1;
        checkCount++;
        if (stall_id !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL flush_stall got=%b exp=0", stall_id);
        end
        step();
        got = dut_out(); exp = sbq.pop_front();
        checkCount++;
        if (got !== exp || bubble_cnt !== 4'd1) begin
            errorCount++;
            $display("[TB] FAIL flush_bubble got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_enable();
        out_t got, exp;
        @(negedge clk);
        idle_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        void'(sbq.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0; flush = 1'(i == 1);
            mem_w_en = 1'b1; mem_rd = 5'(i + 1); mem_data = $urandom;
            set_id(1'b1, 5'd12, 5'(i), 5'(i + 3), 1'b1, 1'b0, $urandom, $urandom);
            #1;
            checkCount++;
            if (stall_id !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL en_stall[%0d] got=%b exp=0", i, stall_id);
            end
            step();
            got = dut_out(); exp = sbq.pop_front();
            checkCount++;
            if (got !== exp) begin
                errorCount++;
                $display("[TB] FAIL en_hold[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_saturation();
        out_t got, exp;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            idle_inputs();
            set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, 32'h0, 32'h0);
            step();
            void'(sbq.pop_front());
            @(negedge clk);
            set_id(1'b1, 5'd3, 5'd12, 5'd13, 1'b1, 1'b0, 32'h1, 32'h2);
            step();
            got = dut_out(); exp = sbq.pop_front();
            checkCount++;
            if (got !== exp) begin
                errorCount++;
                $display("[TB] FAIL sat_step[%0d] got=%h exp=%h", i, got, exp);
            end
        end
        checkCount++;
        if (bubble_cnt !== 4'hF) begin
            errorCount++;
            $display("[TB] FAIL sat_final got=%h exp=f", bubble_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        idle_inputs();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        void'(sbq.pop_front());
        @(negedge clk);
        set_id(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2);
        #1;
        checkCount++;
        if (stall_id !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL rst_pre_stall got=%b exp=1", stall_id);
        end
        rst_n = 1'b0;
        #1;
        mdl = '0;
        sbq.delete();
        checkCount++;
        if (stall_id !== 1'b0 || dut_out() !== out_t'(0)) begin
            errorCount++;
            $display("[TB] FAIL rst_mid_stall stall=%b out=%h exp=0", stall_id, dut_out());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mdl = '0;
        test_reset();
        test_ex_forward();
        test_fwd_priority();
        test_load_use();
        test_flush_hazard();
        test_enable();
        test_saturation();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
